// File: rtl/prm_edge_mask_collector_pkg.sv
// Shared types and sizing helpers for the PRM blocked-edge mask collector.
package prm_collector_pkg;

  localparam int CODE_W_DEF = 15;
  localparam int OUT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_e;

  function automatic int words(input int num_edges, input int out_w);
    return num_edges / out_w;
  endfunction

  // Keeps index ports at least one bit wide when the bitmap fits one word.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prm_edge_mask_collector_if.sv
// Voxel-code input stream and bitmap drain stream of the mask collector.
interface prm_edge_mask_collector_if
  import prm_collector_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int IDX_W  = 2
);
  // Both streams: a beat transfers on a rising edge where valid and ready are
  // both high; once valid rises the source holds it and its payload unchanged
  // until that transfer, and ready may change freely.
  logic              obs_valid;
  logic              obs_ready;
  logic [CODE_W-1:0] obs_code;
  logic              obs_last;

  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  modport master (
    output obs_valid, obs_code, obs_last, out_ready,
    input  obs_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  obs_valid, obs_code, obs_last, out_ready,
    output obs_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/prm_mask_word_sel.sv
// Combinational word mux over the blocked-edge bitmap for the drain stream.
module prm_mask_word_sel #(
  parameter int NUM_EDGES = 64,
  parameter int OUT_W     = 16,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_EDGES-1:0] acc,
  input  logic [IDX_W-1:0]     idx,
  output logic [OUT_W-1:0]     data,
  output logic                 last
);

  localparam int WORDS = NUM_EDGES / OUT_W;

  always_comb begin
    data = acc[int'(idx)*OUT_W +: OUT_W];
    last = (int'(idx) == WORDS - 1);
  end

endmodule

// File: rtl/prm_edge_mask_collector.sv
// Feeds voxel codes to the external edge checker bank, ORs the returned edge
// masks into a blocked-edge bitmap and drains it word by word at end of frame.
module prm_edge_mask_collector
  import prm_collector_pkg::*;
#(
  parameter int NUM_EDGES = 64,
  parameter int CODE_W    = CODE_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int CNT_W     = 16,
  localparam int WORDS    = words(NUM_EDGES, OUT_W),
  localparam int IDX_W    = idx_w(WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  prm_edge_mask_collector_if.slave bus,
  output logic [CODE_W-1:0]    chk_code,
  input  logic [NUM_EDGES-1:0] chk_mask,
  output logic [CNT_W-1:0]     voxel_count,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  state_e               state;
  logic                 stage_vld;
  logic [NUM_EDGES-1:0] acc;
  logic [IDX_W-1:0]     idx;
  logic                 obs_ready;
  logic                 accept;
  logic                 out_valid;
  logic                 take;
  logic [OUT_W-1:0]     sel_data;
  logic                 sel_last;

  assign obs_ready = ~rst & ((state == IDLE) || (state == ACCUM));
  assign accept    = bus.obs_valid & obs_ready;
  assign out_valid = (state == DRAIN);
  assign take      = out_valid & bus.out_ready;

  assign bus.obs_ready = obs_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? sel_data : '0;
  assign bus.out_last  = out_valid & sel_last;
  assign bus.out_idx   = idx;
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

  prm_mask_word_sel #(
    .NUM_EDGES (NUM_EDGES),
    .OUT_W     (OUT_W),
    .IDX_W     (IDX_W)
  ) u_word_sel (
    .acc  (acc),
    .idx  (idx),
    .data (sel_data),
    .last (sel_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      stage_vld   <= 1'b0;
      acc         <= '0;
      chk_code    <= '0;
      idx         <= '0;
      voxel_count <= '0;
    end else begin
      // chk_mask answers for the code registered one cycle earlier; stage_vld
      // marks that cycle so a held code is never ORed in twice.
      stage_vld <= accept;
      if (accept) chk_code <= bus.obs_code;
      if (stage_vld) acc <= acc | chk_mask;

      case (state)
        IDLE: begin
          if (accept) begin
            voxel_count <= CNT_W'(1);
            state       <= bus.obs_last ? FLUSH : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (voxel_count != '1) voxel_count <= voxel_count + CNT_W'(1);
            if (bus.obs_last) state <= FLUSH;
          end
        end
        FLUSH: begin
          state <= DRAIN;
          idx   <= '0;
        end
        DRAIN: begin
          if (take) begin
            if (sel_last) begin
              state <= IDLE;
              idx   <= '0;
              acc   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
